// File: rtl/multiply_sum_post_pkg.sv
// Shared constants and helpers for the multiply_sum post-processing stage.
// Default widths/latency mirror the multiply_sum build constants.
package multiply_sum_post_pkg;

    localparam int REG_WIDTH  = 16;
    localparam int SUM_W      = REG_WIDTH + 7;
    localparam int POST_OUT_W = 16;
    localparam int POST_SHIFT = 4;
    localparam int POST_DEPTH = 4;
    localparam int MS_LAT     = 3;

    typedef logic [15:0] sat_cnt_t;

    function automatic sat_cnt_t sat_inc(input sat_cnt_t c);
        return (c == '1) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/multiply_sum_post_if.sv
// Issue credit and result stream between the issuer, multiply_sum and the consumer.
// The slave side is the post stage; the master side is the surrounding logic.
interface multiply_sum_post_if
    import multiply_sum_post_pkg::*;
#(
    parameter int SUM_W = multiply_sum_post_pkg::SUM_W,
    parameter int OUT_W = POST_OUT_W
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic signed [SUM_W-1:0] sum_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic signed [OUT_W-1:0] out_data_o;
    logic                    out_sat_o;
    logic                    drop_o;
    logic [15:0]             sat_count_o;

    modport slave (
        input  in_valid_i, sum_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_sat_o, drop_o, sat_count_o
    );

    modport master (
        output in_valid_i, sum_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_sat_o, drop_o, sat_count_o
    );
endinterface

// File: rtl/multiply_sum_post_fifo.sv
// Synchronous FIFO holding {sat, result} entries; count register drives full/empty.
// No bypass: a push into an empty FIFO becomes visible on the next cycle.
module multiply_sum_post_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only read once the count says they exist.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/multiply_sum_post.sv
// Post stage for multiply_sum: tracks valid issues, rounds/saturates sum, buffers results.
// multiply_sum cannot stall, so in_ready_o is a credit covering buffered plus in-flight results.
module multiply_sum_post
    import multiply_sum_post_pkg::*;
#(
    parameter int OUT_W  = POST_OUT_W,
    parameter int SHIFT  = POST_SHIFT,
    parameter int DEPTH  = POST_DEPTH,
    parameter int MS_LAT = multiply_sum_post_pkg::MS_LAT
) (
    input logic               clk,
    input logic               rst,
    multiply_sum_post_if.slave bus
);
    localparam int EXT_W = SUM_W + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CR_W  = $clog2(DEPTH + MS_LAT + 1);

    localparam logic signed [EXT_W-1:0] RND    = EXT_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-(64'sd1 <<< (OUT_W - 1)));

    logic [MS_LAT-1:0]       vline;
    logic [CR_W-1:0]         inflight;
    logic                    in_ready;
    logic                    accept;
    logic                    push;
    logic signed [EXT_W-1:0] t;
    logic signed [EXT_W-1:0] r;
    logic signed [OUT_W-1:0] res;
    logic                    sat;
    logic [OUT_W:0]          fifo_dout;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop;
    sat_cnt_t                sat_count;

    assign accept = bus.in_valid_i & in_ready;
    assign push   = vline[MS_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) vline <= '0;
        else     vline <= (vline << 1) | MS_LAT'(accept);
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MS_LAT; i++) begin
            inflight = inflight + CR_W'(vline[i]);
        end
    end

    // Credit counts registered state only, so a pop frees a slot one cycle later.
    assign in_ready = (CR_W'(fifo_count) + inflight) < CR_W'(DEPTH);

    always_comb begin
        t   = {bus.sum_i[SUM_W-1], bus.sum_i} + RND;
        r   = t >>> SHIFT;
        sat = 1'b0;
        res = r[OUT_W-1:0];
        if (r > SAT_HI) begin
            res = SAT_HI[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < SAT_LO) begin
            res = SAT_LO[OUT_W-1:0];
            sat = 1'b1;
        end
    end

    multiply_sum_post_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.out_ready_i),
        .din   ({sat, res}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            drop      <= 1'b0;
            sat_count <= '0;
        end else begin
            drop <= bus.in_valid_i & ~in_ready;
            if (push && sat) sat_count <= sat_inc(sat_count);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full));
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = ~fifo_empty;
    assign bus.out_data_o  = fifo_empty ? '0 : fifo_dout[OUT_W-1:0];
    assign bus.out_sat_o   = fifo_empty ? 1'b0 : fifo_dout[OUT_W];
    assign bus.drop_o      = drop;
    assign bus.sat_count_o = sat_count;

endmodule

// File: tb/tb_multiply_sum_post.sv
// Directed and random checks of multiply_sum_post against a queue-based reference.
module tb_multiply_sum_post;
    import multiply_sum_post_pkg::*;

    localparam int OUT_W = POST_OUT_W;
    localparam int SHIFT = POST_SHIFT;
    localparam int DEPTH = POST_DEPTH;
    localparam int LAT   = multiply_sum_post_pkg::MS_LAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiply_sum_post_if #(.SUM_W(SUM_W), .OUT_W(OUT_W)) bus();

    multiply_sum_post #(
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH),
        .MS_LAT(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { longint issued; longint sum; } issue_t;
    typedef struct { longint data; bit sat; } res_t;

    issue_t inflight[$];
    res_t   fifo_q[$];
    longint planned[$];
    longint cyc_n;
    bit     exp_drop;
    int     exp_satcnt;
    bit     exp_ready;
    bit     cur_due;
    int     tests = 0;
    int     fails = 0;

    function automatic longint floor_div(longint a, longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic res_t ref_round(longint s);
        res_t   o;
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        longint lo = -(longint'(1) << (OUT_W - 1));
        longint q  = floor_div(s + (longint'(1) << (SHIFT - 1)), longint'(1) << SHIFT);
        o.sat = 1'b0;
        o.data = q;
        if (q > hi) begin o.data = hi; o.sat = 1'b1; end
        else if (q < lo) begin o.data = lo; o.sat = 1'b1; end
        return o;
    endfunction

    function automatic longint rand_sum();
        logic [SUM_W-1:0] v;
        if ($urandom_range(0, 1) == 1) v = SUM_W'($urandom);
        else v = SUM_W'(longint'($urandom_range(0, 1 << 20)) - (longint'(1) << 19));
        return longint'($signed(v));
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit iv, input bit ordy);
        res_t head;
        bus.in_valid_i  = iv;
        bus.out_ready_i = ordy;
        cur_due = (inflight.size() > 0) && (inflight[0].issued == cyc_n - LAT);
        bus.sum_i = cur_due ? SUM_W'(inflight[0].sum) : SUM_W'(rand_sum());
        exp_ready = (fifo_q.size() + inflight.size()) < DEPTH;
        @(negedge clk);
        head = (fifo_q.size() > 0) ? fifo_q[0] : '{0, 1'b0};
        chk("in_ready", longint'(bus.in_ready_o), longint'(exp_ready));
        chk("out_valid", longint'(bus.out_valid_o), longint'(fifo_q.size() > 0));
        chk("out_data", longint'(bus.out_data_o), head.data);
        chk("out_sat", longint'(bus.out_sat_o), longint'(head.sat));
        chk("drop", longint'(bus.drop_o), longint'(exp_drop));
        chk("sat_count", longint'(bus.sat_count_o), longint'(exp_satcnt));
    endtask

    task automatic adv();
        res_t   rs;
        longint s;
        @(posedge clk);
        if (fifo_q.size() > 0 && bus.out_ready_i) void'(fifo_q.pop_front());
        if (cur_due) begin
            rs = ref_round(inflight[0].sum);
            fifo_q.push_back(rs);
            if (rs.sat && exp_satcnt < 65535) exp_satcnt++;
            void'(inflight.pop_front());
        end
        if (bus.in_valid_i && exp_ready) begin
            s = (planned.size() > 0) ? planned.pop_front() : rand_sum();
            inflight.push_back('{cyc_n, s});
        end
        exp_drop = bus.in_valid_i && !exp_ready;
        cyc_n++;
        #1;
    endtask

    task automatic step(input bit iv, input bit ordy);
        cyc(iv, ordy);
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        @(posedge clk);
        inflight.delete();
        fifo_q.delete();
        planned.delete();
        exp_drop = 1'b0;
        exp_satcnt = 0;
        cyc_n = 0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int seen;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.sum_i       = '0;

        // Reset state and single-issue latency/rounding: 37 -> 2 at cycle 4
        do_reset();
        planned.push_back(37);
        cyc(1, 1);
        chk("rst_in_ready", longint'(bus.in_ready_o), 1);
        chk("rst_out_valid", longint'(bus.out_valid_o), 0);
        chk("rst_out_data", longint'(bus.out_data_o), 0);
        chk("rst_sat_count", longint'(bus.sat_count_o), 0);
        adv();
        for (int i = 1; i < 4; i++) begin
            cyc(0, 1);
            chk("lat_early_valid", longint'(bus.out_valid_o), 0);
            adv();
        end
        cyc(0, 1);
        chk("lat_valid_c4", longint'(bus.out_valid_o), 1);
        chk("lat_data_c4", longint'(bus.out_data_o), 2);
        chk("lat_sat_c4", longint'(bus.out_sat_o), 0);
        adv();
        cyc(0, 1);
        chk("lat_valid_c5", longint'(bus.out_valid_o), 0);
        adv();

        // Negative rounding, including the half-toward-+inf case
        do_reset();
        planned = '{-40, -24, -8};
        for (int i = 0; i < 3; i++) step(1, 1);
        step(0, 1);
        cyc(0, 1); chk("neg_m40", longint'(bus.out_data_o), -2); adv();
        cyc(0, 1); chk("neg_m24", longint'(bus.out_data_o), -1); adv();
        cyc(0, 1); chk("neg_m8", longint'(bus.out_data_o), 0);
        chk("neg_m8_valid", longint'(bus.out_valid_o), 1); adv();
        step(0, 1);

        // Saturation boundaries: -2^19 rounds exactly onto the minimum without clamping
        do_reset();
        planned = '{524288, -524288, -524320};
        for (int i = 0; i < 3; i++) step(1, 1);
        step(0, 1);
        cyc(0, 1); chk("sat_hi", longint'(bus.out_data_o), 32767);
        chk("sat_hi_flag", longint'(bus.out_sat_o), 1); adv();
        cyc(0, 1); chk("min_exact", longint'(bus.out_data_o), -32768);
        chk("min_exact_flag", longint'(bus.out_sat_o), 0); adv();
        cyc(0, 1); chk("sat_lo", longint'(bus.out_data_o), -32768);
        chk("sat_lo_flag", longint'(bus.out_sat_o), 1); adv();
        cyc(0, 1); chk("sat_count_2", longint'(bus.sat_count_o), 2); adv();

        // Back-pressure: only DEPTH issues accepted, head held stable
        do_reset();
        planned = '{100, 200, 300, 400};
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1, 0);
            if (bus.in_ready_o) acc++;
            if (c >= 4) begin
                chk("bp_ready_low", longint'(bus.in_ready_o), 0);
                chk("bp_head", longint'(bus.out_data_o), 6);
            end
            adv();
        end
        chk("bp_accepted", longint'(acc), 4);
        step(0, 0);
        step(0, 0);
        cyc(0, 0); chk("drop_idle", longint'(bus.drop_o), 0); adv();
        step(1, 0);
        cyc(0, 0); chk("drop_pulse", longint'(bus.drop_o), 1); adv();
        cyc(0, 0); chk("drop_clear", longint'(bus.drop_o), 0); adv();
        cyc(0, 1); chk("pop_no_credit_yet", longint'(bus.in_ready_o), 0); adv();
        cyc(0, 0); chk("credit_restored", longint'(bus.in_ready_o), 1);
        chk("bp_second_head", longint'(bus.out_data_o), 13); adv();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(0, 1);
            if (bus.out_valid_o) seen++;
            adv();
        end
        chk("bp_remaining", longint'(seen), 3);

        // Reset mid-stream with two buffered and two in flight
        do_reset();
        planned = '{2097152, 2097152, 2097152, 2097152};
        for (int c = 0; c < 4; c++) step(1, 0);
        step(0, 0);
        cyc(0, 0);
        chk("pre_rst_sat_count", longint'(bus.sat_count_o), 2);
        do_reset();
        cyc(0, 1);
        chk("post_rst_valid", longint'(bus.out_valid_o), 0);
        chk("post_rst_ready", longint'(bus.in_ready_o), 1);
        chk("post_rst_sat_count", longint'(bus.sat_count_o), 0);
        adv();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(0, 1);
            if (bus.out_valid_o) seen++;
            adv();
        end
        chk("post_rst_no_stale", longint'(seen), 0);

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        for (int c = 0; c < 12; c++) step(0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
